pwm_led_generator: RTL

Downstream consumer of the 8-bit PWM duty PIO register in the LED slider design. It turns the programmed duty value into a glitch-free PWM waveform for one LED channel. A prescaler sets the PWM tick rate. The applied duty is only updated at period boundaries, and an optional per-period slew limit gives smooth fades. Output polarity is selectable per board.

---
 rtl/pwm_led_if.sv | 19 +
 rtl/pwm_led_generator.sv | 72 +++++++
 2 files changed

// File: rtl/pwm_led_if.sv
// Signal bundle between the duty-register side and one PWM LED channel.
interface pwm_led_if;
  logic       enable;
  logic [7:0] duty_in;
  logic       pwm_out;
  logic       period_end;
  logic [7:0] cur_duty;
  logic       ramping;

  modport master (
    output enable, duty_in,
    input  pwm_out, period_end, cur_duty, ramping
  );

  modport slave (
    input  enable, duty_in,
    output pwm_out, period_end, cur_duty, ramping
  );
endinterface

// File: rtl/pwm_led_generator.sv
// Single-channel LED PWM: prescaled 255-tick period, duty applied only at period
// boundaries with an optional per-period slew limit, selectable output polarity.
module pwm_led_generator #(
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned STEP     = 4,
  parameter bit          OUT_POL  = 1'b1
) (
  input logic     clk,
  input logic     reset_n,
  pwm_led_if.slave bus
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [8:0]  STEP9    = 9'(STEP);

  logic [15:0] pre_cnt;
  logic [7:0]  cnt;
  logic [7:0]  cur_duty;
  logic [7:0]  next_duty;
  logic        pwm_q;
  logic        period_end_q;
  logic        tick;
  logic        wrap;
  logic        going_up;
  logic [8:0]  diff;
  logic [8:0]  delta;
  logic [8:0]  stepped;

  always_comb begin
    tick = bus.enable && (pre_cnt == PRE_LAST);
    wrap = tick && (cnt == 8'd254);
  end

  // Slew toward the target in 9 bits so the step is clamped to the remaining distance.
  always_comb begin
    going_up  = (bus.duty_in >= cur_duty);
    diff      = going_up ? ({1'b0, bus.duty_in} - {1'b0, cur_duty})
                         : ({1'b0, cur_duty} - {1'b0, bus.duty_in});
    delta     = (diff > STEP9) ? STEP9 : diff;
    stepped   = going_up ? ({1'b0, cur_duty} + delta) : ({1'b0, cur_duty} - delta);
    next_duty = bus.duty_in;
    if (STEP != 0) next_duty = stepped[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt      <= '0;
      cnt          <= '0;
      cur_duty     <= 8'd128;
      pwm_q        <= ~OUT_POL;
      period_end_q <= 1'b0;
    end else if (!bus.enable) begin
      // Idle: counters cleared so re-enable starts a whole fresh period.
      pre_cnt      <= '0;
      cnt          <= '0;
      pwm_q        <= ~OUT_POL;
      period_end_q <= 1'b0;
    end else begin
      pre_cnt      <= tick ? 16'd0 : pre_cnt + 16'd1;
      period_end_q <= wrap;
      if (tick) cnt <= wrap ? 8'd0 : cnt + 8'd1;
      if (wrap) cur_duty <= next_duty;
      pwm_q        <= (cnt < cur_duty) ? OUT_POL : ~OUT_POL;
    end
  end

  assign bus.pwm_out    = pwm_q;
  assign bus.period_end = period_end_q;
  assign bus.cur_duty   = cur_duty;
  assign bus.ramping    = (cur_duty != bus.duty_in);

endmodule
